// File: rtl/des3_llki_key_driver.sv
// des3_llki_key_driver
// Upstream LLKI key driver for the DES3 mock-TSS wrapper. A load command
// pulls KEY_WORDS 64-bit words from the key-store stream and hands them to
// the TSS over the LLKI discrete interface, then waits for key-complete.
// A clear command runs the clear-key / clear-ack handshake. Every accepted
// command produces exactly one status response.
//
// Parameters: KEY_WORDS (1..16) words per load, TIMEOUT_CYCLES (>= 2)
// maximum wait on any LLKI handshake before the operation is aborted.
//
// Optional build macro: DES3_KEY_DRIVER_AUTOCLEAR_EN
//   When defined, a load that aborts with a timeout or a sequence error
//   first runs the clear handshake, and its response carries bit 2 set
//   (timeout -> 6, sequence error -> 4, clear itself timing out -> 7).
//   When undefined, aborts respond immediately and the TSS key register
//   contents are left as they are.
//
// Status codes: 0 load OK, 1 clear OK, 2 timeout, 3 illegal op,
// 4 sequence error.

module des3_llki_key_driver #(
   parameter int KEY_WORDS      = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [63:0] kw_data,
   input  logic        kw_valid,
   output logic        kw_ready,
   output logic [63:0] llkid_key_data,
   output logic        llkid_key_valid,
   input  logic        llkid_key_ready,
   input  logic        llkid_key_complete,
   output logic        llkid_clear_key,
   input  logic        llkid_clear_key_ack,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [2:0]  rsp_status,
   output logic        busy
);

   // Word counter must hold KEY_WORDS itself after the last word is taken.
   localparam int WCW = $clog2(KEY_WORDS + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES);

   localparam logic [WCW-1:0] LAST_WORD    = WCW'(KEY_WORDS - 1);
   localparam logic [WCW-1:0] WORD_ONE     = WCW'(1);
   localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);
   localparam logic [TCW-1:0] TICK_ONE     = TCW'(1);

   localparam logic [2:0] ST_LOAD_OK  = 3'd0;
   localparam logic [2:0] ST_CLEAR_OK = 3'd1;
   localparam logic [2:0] ST_TIMEOUT  = 3'd2;
   localparam logic [2:0] ST_ILLEGAL  = 3'd3;
   localparam logic [2:0] ST_SEQ_ERR  = 3'd4;
`ifdef DES3_KEY_DRIVER_AUTOCLEAR_EN
   localparam logic [2:0] ST_AUTOCLR_FLAG    = 3'd4;
   localparam logic [2:0] ST_AUTOCLR_TIMEOUT = 3'd7;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SEND,
      S_WAIT_CPL,
      S_CLEAR,
      S_RESP
   } state_e;

   state_e          state_q, state_d;
   logic [WCW-1:0]  wcnt_q, wcnt_d;
   logic [TCW-1:0]  tcnt_q, tcnt_d;
   logic [63:0]     hold_q, hold_d;
   logic [2:0]      status_q, status_d;

   logic            cmd_ready_q, cmd_ready_d;
   logic            kw_ready_q, kw_ready_d;
   logic            key_valid_q, key_valid_d;
   logic            clear_key_q, clear_key_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            busy_q, busy_d;

   logic            abort_req;
   logic [2:0]      abort_code;

`ifdef DES3_KEY_DRIVER_AUTOCLEAR_EN
   logic            autoclr_q, autoclr_d;
`endif

   // Next-state logic: command dispatch, word transfer, completion wait,
   // clear handshake and the shared handshake timeout. Handshake events
   // are tested before the timeout so a same-cycle acceptance always wins.
   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      tcnt_d     = tcnt_q;
      hold_d     = hold_q;
      status_d   = status_q;
      abort_req  = 1'b0;
      abort_code = ST_TIMEOUT;
`ifdef DES3_KEY_DRIVER_AUTOCLEAR_EN
      autoclr_d  = autoclr_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  2'b00: begin
                     state_d = S_FETCH;
                     wcnt_d  = '0;
                  end
                  2'b01: begin
                     state_d = S_CLEAR;
                  end
                  default: begin
                     state_d  = S_RESP;
                     status_d = ST_ILLEGAL;
                  end
               endcase
            end
         end

         S_FETCH: begin
            if (llkid_key_complete) begin
               abort_req  = 1'b1;
               abort_code = ST_SEQ_ERR;
            end else if (kw_valid) begin
               hold_d  = kw_data;
               state_d = S_SEND;
            end
         end

         S_SEND: begin
            if (llkid_key_ready && (wcnt_q == LAST_WORD)) begin
               wcnt_d  = wcnt_q + WORD_ONE;
               state_d = S_WAIT_CPL;
            end else if (llkid_key_complete) begin
               abort_req  = 1'b1;
               abort_code = ST_SEQ_ERR;
            end else if (llkid_key_ready) begin
               wcnt_d  = wcnt_q + WORD_ONE;
               state_d = S_FETCH;
            end else if (tcnt_q == TIMEOUT_LAST) begin
               abort_req  = 1'b1;
               abort_code = ST_TIMEOUT;
            end else begin
               tcnt_d = tcnt_q + TICK_ONE;
            end
         end

         S_WAIT_CPL: begin
            if (llkid_key_complete) begin
               state_d  = S_RESP;
               status_d = ST_LOAD_OK;
            end else if (tcnt_q == TIMEOUT_LAST) begin
               abort_req  = 1'b1;
               abort_code = ST_TIMEOUT;
            end else begin
               tcnt_d = tcnt_q + TICK_ONE;
            end
         end

         S_CLEAR: begin
            if (llkid_clear_key_ack) begin
               state_d = S_RESP;
`ifdef DES3_KEY_DRIVER_AUTOCLEAR_EN
               status_d = autoclr_q ? (status_q | ST_AUTOCLR_FLAG) : ST_CLEAR_OK;
`else
               status_d = ST_CLEAR_OK;
`endif
            end else if (tcnt_q == TIMEOUT_LAST) begin
               state_d = S_RESP;
`ifdef DES3_KEY_DRIVER_AUTOCLEAR_EN
               status_d = autoclr_q ? ST_AUTOCLR_TIMEOUT : ST_TIMEOUT;
`else
               status_d = ST_TIMEOUT;
`endif
            end else begin
               tcnt_d = tcnt_q + TICK_ONE;
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               state_d  = S_IDLE;
               status_d = '0;
`ifdef DES3_KEY_DRIVER_AUTOCLEAR_EN
               autoclr_d = 1'b0;
`endif
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A load abort either responds at once or, with auto-clear, first
      // wipes the TSS key register while remembering the error code.
      if (abort_req) begin
`ifdef DES3_KEY_DRIVER_AUTOCLEAR_EN
         state_d   = S_CLEAR;
         autoclr_d = 1'b1;
`else
         state_d   = S_RESP;
`endif
         status_d  = abort_code;
      end

      // Every state change (including an accepted word) restarts the wait.
      if (state_d != state_q) begin
         tcnt_d = '0;
      end

      cmd_ready_d = (state_d == S_IDLE);
      kw_ready_d  = (state_d == S_FETCH);
      key_valid_d = (state_d == S_SEND);
      clear_key_d = (state_d == S_CLEAR);
      rsp_valid_d = (state_d == S_RESP);
      busy_d      = (state_d != S_IDLE);
   end

   // State, counters, holding register and registered handshake outputs;
   // reset drops everything at once so an interrupted operation vanishes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         wcnt_q      <= '0;
         tcnt_q      <= '0;
         hold_q      <= '0;
         status_q    <= '0;
         cmd_ready_q <= 1'b1;
         kw_ready_q  <= 1'b0;
         key_valid_q <= 1'b0;
         clear_key_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef DES3_KEY_DRIVER_AUTOCLEAR_EN
         autoclr_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         tcnt_q      <= tcnt_d;
         hold_q      <= hold_d;
         status_q    <= status_d;
         cmd_ready_q <= cmd_ready_d;
         kw_ready_q  <= kw_ready_d;
         key_valid_q <= key_valid_d;
         clear_key_q <= clear_key_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
`ifdef DES3_KEY_DRIVER_AUTOCLEAR_EN
         autoclr_q   <= autoclr_d;
`endif
      end
   end

   // Key data and status are only driven while their valid is up, so the
   // bus reads zero whenever nothing is being offered.
   assign cmd_ready       = cmd_ready_q;
   assign kw_ready        = kw_ready_q;
   assign llkid_key_valid = key_valid_q;
   assign llkid_key_data  = key_valid_q ? hold_q : 64'd0;
   assign llkid_clear_key = clear_key_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_status      = rsp_valid_q ? status_q : 3'd0;
   assign busy            = busy_q;

endmodule
